key_debounce_ctrl: RTL and testbench

Upstream front end of the device-switch stage. Takes one raw, bouncing push-button input and synchronises it. It debounces the button and classifies each press as short or long. It produces the level key_state consumed by the device-switch stage, plus single-cycle event pulses and a 2-bit mode register for classification control.

---
 rtl/key_debounce_ctrl_if.sv | 11 +
 rtl/key_debounce_ctrl.sv | 146 ++++++++++++++
 tb/tb_key_debounce_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_ctrl_if.sv
// rtl/key_debounce_ctrl_if.sv - raw button input and debounced key event bundle
interface key_debounce_ctrl_if;
  logic       key_in;
  logic       key_state;
  logic       key_press;
  logic       key_long;
  logic [1:0] mode;

  modport master (input key_in, output key_state, key_press, key_long, mode);
  modport slave  (output key_in, input key_state, key_press, key_long, mode);
endinterface

// File: rtl/key_debounce_ctrl.sv
// rtl/key_debounce_ctrl.sv - push-button debouncer with short/long press classification
module key_debounce_ctrl #(
  parameter int DEBOUNCE_CYC   = 1000000,
  parameter int LONG_CYC       = 50000000,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  key_debounce_ctrl_if.master kif
);

  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam int HW = $clog2(LONG_CYC);
  localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] H_LAST  = HW'(LONG_CYC - 1);
  // hcnt value one step before saturation: the long event fires on the
  // cycle hcnt moves onto LONG_CYC-1
  localparam logic [HW-1:0] H_FIRE  = HW'(LONG_CYC - 2);
  localparam logic          REL_LVL = KEY_ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic          pressed_s;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          long_fired_q, long_fired_d;
  logic          key_state_q, key_state_d;
  logic          key_press_q, key_press_d;
  logic          key_long_q, key_long_d;
  logic [1:0]    mode_q, mode_d;

  // Two-flop synchroniser; resets to the released level so a still-held
  // button has to pass the full press debounce after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {2{REL_LVL}};
    else        sync_q <= {sync_q[0], kif.key_in};
  end

  // Polarity correction: 1 means pressed regardless of button wiring
  assign pressed_s = sync_q[1] ^ REL_LVL;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state decision from the synchronised button level
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (pressed_s) state_d = PRESS_WAIT;
      PRESS_WAIT:   if (!pressed_s) state_d = IDLE;
                    else if (dcnt_q == D_LAST) state_d = HELD;
      HELD:         if (!pressed_s) state_d = RELEASE_WAIT;
      RELEASE_WAIT: if (pressed_s) state_d = HELD;
                    else if (dcnt_q == D_LAST) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // FSM outputs: counter updates and next values of the registered outputs
  always_comb begin
    dcnt_d       = dcnt_q;
    hcnt_d       = hcnt_q;
    long_fired_d = long_fired_q;
    key_state_d  = key_state_q;
    key_press_d  = 1'b0;
    key_long_d   = 1'b0;
    mode_d       = mode_q;
    case (state_q)
      IDLE: begin
        if (pressed_s) dcnt_d = '0;
      end
      PRESS_WAIT: begin
        if (pressed_s) begin
          if (dcnt_q == D_LAST) begin
            key_press_d  = 1'b1;
            hcnt_d       = '0;
            long_fired_d = 1'b0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      HELD: begin
        if (!pressed_s) begin
          dcnt_d = '0;
        end else if (hcnt_q != H_LAST) begin
          hcnt_d = hcnt_q + 1'b1;
          if (hcnt_q == H_FIRE && !long_fired_q) begin
            key_long_d   = 1'b1;
            mode_d       = mode_q + 2'd1;
            long_fired_d = 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        // hcnt and long_fired are left alone so a bounce back to HELD
        // resumes the same press
        if (!pressed_s) begin
          if (dcnt_q == D_LAST) begin
            if (!long_fired_q) key_state_d = ~key_state_q;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Counters, flags and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q       <= '0;
      hcnt_q       <= '0;
      long_fired_q <= 1'b0;
      key_state_q  <= 1'b0;
      key_press_q  <= 1'b0;
      key_long_q   <= 1'b0;
      mode_q       <= 2'd0;
    end else begin
      dcnt_q       <= dcnt_d;
      hcnt_q       <= hcnt_d;
      long_fired_q <= long_fired_d;
      key_state_q  <= key_state_d;
      key_press_q  <= key_press_d;
      key_long_q   <= key_long_d;
      mode_q       <= mode_d;
    end
  end

  assign kif.key_state = key_state_q;
  assign kif.key_press = key_press_q;
  assign kif.key_long  = key_long_q;
  assign kif.mode      = mode_q;

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// tb/tb_key_debounce_ctrl.sv - scoreboard bench for key_debounce_ctrl
module tb_key_debounce_ctrl;

  localparam int DEB = 8;
  localparam int LNG = 32;
  // edges from the drive edge to the FSM first seeing the new level: 2 sync + 1
  localparam int LAT = 3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  int         cyc = 0;
  int         vectors = 0;
  int         errors = 0;
  logic [1:0] exp_mode;
  logic       exp_state;
  logic       prev_l, prev_h;
  ev_t        exp_l[$], act_l[$], exp_h[$], act_h[$];

  key_debounce_ctrl_if kif_l ();
  key_debounce_ctrl_if kif_h ();

  key_debounce_ctrl #(.DEBOUNCE_CYC(DEB), .LONG_CYC(LNG), .KEY_ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .kif(kif_l.master));

  key_debounce_ctrl #(.DEBOUNCE_CYC(DEB), .LONG_CYC(LNG), .KEY_ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .kif(kif_h.master));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input logic [1:0] k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    return e;
  endfunction

  function automatic string kname(input logic [1:0] k);
    case (k)
      2'd0:    return "key_press";
      2'd1:    return "key_long";
      default: return "key_state_toggle";
    endcase
  endfunction

  // Output monitor: logs every pulse and key_state change with its cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (kif_l.key_press === 1'b1) act_l.push_back(mk(2'd0, cyc));
      if (kif_l.key_long === 1'b1) act_l.push_back(mk(2'd1, cyc));
      if (kif_l.key_state !== prev_l) act_l.push_back(mk(2'd2, cyc));
      if (kif_h.key_press === 1'b1) act_h.push_back(mk(2'd0, cyc));
      if (kif_h.key_long === 1'b1) act_h.push_back(mk(2'd1, cyc));
      if (kif_h.key_state !== prev_h) act_h.push_back(mk(2'd2, cyc));
    end
    prev_l = kif_l.key_state;
    prev_h = kif_h.key_state;
  end

  task automatic press_lo(input int n, output int c);
    @(negedge clk);
    c = cyc;
    kif_l.key_in = 1'b0;
    repeat (n) @(negedge clk);
    kif_l.key_in = 1'b1;
  endtask

  task automatic test_reset;
    ev_t e, a;
    rst_n = 1'b0;
    repeat (10) begin
      @(negedge clk);
      vectors++;
      if ({kif_l.key_state, kif_l.key_press, kif_l.key_long, kif_l.mode} !== 5'b0) begin
        errors++;
        $display("FAIL reset_outputs_lo: got %b, expected 00000",
                 {kif_l.key_state, kif_l.key_press, kif_l.key_long, kif_l.mode});
      end
      vectors++;
      if ({kif_h.key_state, kif_h.key_press, kif_h.key_long, kif_h.mode} !== 5'b0) begin
        errors++;
        $display("FAIL reset_outputs_hi: got %b, expected 00000",
                 {kif_h.key_state, kif_h.key_press, kif_h.key_long, kif_h.mode});
      end
      kif_l.key_in = 1'($urandom_range(1));
      kif_h.key_in = 1'($urandom_range(1));
    end
    kif_l.key_in = 1'b1;
    kif_h.key_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if (act_l.size() != 0) begin
      errors++;
      $display("FAIL reset_quiet: got %0d events after reset, expected 0", act_l.size());
    end
    while (exp_l.size() != 0 || act_l.size() != 0) begin
      vectors++;
      if (act_l.size() == 0) begin
        e = exp_l.pop_front(); errors++;
        $display("FAIL reset_missing: got none, expected %s at cycle %0d", kname(e.kind), e.cyc);
      end else if (exp_l.size() == 0) begin
        a = act_l.pop_front(); errors++;
        $display("FAIL reset_extra: got %s at cycle %0d, expected none", kname(a.kind), a.cyc);
      end else begin
        e = exp_l.pop_front(); a = act_l.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL reset_event: got %s at cycle %0d, expected %s at cycle %0d",
                   kname(a.kind), a.cyc, kname(e.kind), e.cyc);
        end
      end
    end
  endtask

  task automatic test_glitch;
    int c;
    ev_t e, a;
    press_lo(5, c);
    repeat (20) @(negedge clk);
    vectors++;
    if (kif_l.key_state !== exp_state) begin
      errors++;
      $display("FAIL glitch_state: got %b, expected %b", kif_l.key_state, exp_state);
    end
    vectors++;
    if (act_l.size() != 0) begin
      errors++;
      $display("FAIL glitch_quiet: got %0d events, expected 0", act_l.size());
    end
    while (exp_l.size() != 0 || act_l.size() != 0) begin
      vectors++;
      if (act_l.size() == 0) begin
        e = exp_l.pop_front(); errors++;
        $display("FAIL glitch_missing: got none, expected %s at cycle %0d", kname(e.kind), e.cyc);
      end else if (exp_l.size() == 0) begin
        a = act_l.pop_front(); errors++;
        $display("FAIL glitch_extra: got %s at cycle %0d, expected none", kname(a.kind), a.cyc);
      end else begin
        e = exp_l.pop_front(); a = act_l.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL glitch_event: got %s at cycle %0d, expected %s at cycle %0d",
                   kname(a.kind), a.cyc, kname(e.kind), e.cyc);
        end
      end
    end
  endtask

  task automatic test_short_press;
    int c;
    ev_t e, a;
    press_lo(20, c);
    exp_l.push_back(mk(2'd0, c + LAT + DEB));
    exp_l.push_back(mk(2'd2, c + 20 + LAT + DEB));
    exp_state = ~exp_state;
    repeat (25) @(negedge clk);
    vectors++;
    if (kif_l.key_state !== exp_state) begin
      errors++;
      $display("FAIL short_state: got %b, expected %b", kif_l.key_state, exp_state);
    end
    vectors++;
    if (kif_l.mode !== exp_mode) begin
      errors++;
      $display("FAIL short_mode: got %0d, expected %0d", kif_l.mode, exp_mode);
    end
    while (exp_l.size() != 0 || act_l.size() != 0) begin
      vectors++;
      if (act_l.size() == 0) begin
        e = exp_l.pop_front(); errors++;
        $display("FAIL short_missing: got none, expected %s at cycle %0d", kname(e.kind), e.cyc);
      end else if (exp_l.size() == 0) begin
        a = act_l.pop_front(); errors++;
        $display("FAIL short_extra: got %s at cycle %0d, expected none", kname(a.kind), a.cyc);
      end else begin
        e = exp_l.pop_front(); a = act_l.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL short_event: got %s at cycle %0d, expected %s at cycle %0d",
                   kname(a.kind), a.cyc, kname(e.kind), e.cyc);
        end
      end
    end
  endtask

  task automatic test_bounce;
    int c;
    ev_t e, a;
    @(negedge clk);
    c = cyc;
    kif_l.key_in = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      kif_l.key_in = 1'b1;
      repeat (4) @(negedge clk);
      kif_l.key_in = 1'b0;
      repeat (4) @(negedge clk);
    end
    kif_l.key_in = 1'b1;
    exp_l.push_back(mk(2'd0, c + LAT + DEB));
    exp_l.push_back(mk(2'd2, c + 44 + LAT + DEB));
    exp_state = ~exp_state;
    repeat (25) @(negedge clk);
    vectors++;
    if (kif_l.key_state !== exp_state) begin
      errors++;
      $display("FAIL bounce_state: got %b, expected %b", kif_l.key_state, exp_state);
    end
    while (exp_l.size() != 0 || act_l.size() != 0) begin
      vectors++;
      if (act_l.size() == 0) begin
        e = exp_l.pop_front(); errors++;
        $display("FAIL bounce_missing: got none, expected %s at cycle %0d", kname(e.kind), e.cyc);
      end else if (exp_l.size() == 0) begin
        a = act_l.pop_front(); errors++;
        $display("FAIL bounce_extra: got %s at cycle %0d, expected none", kname(a.kind), a.cyc);
      end else begin
        e = exp_l.pop_front(); a = act_l.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL bounce_event: got %s at cycle %0d, expected %s at cycle %0d",
                   kname(a.kind), a.cyc, kname(e.kind), e.cyc);
        end
      end
    end
  endtask

  task automatic test_long_press;
    int c;
    ev_t e, a;
    for (int i = 0; i < 4; i++) begin
      press_lo(100, c);
      exp_l.push_back(mk(2'd0, c + LAT + DEB));
      exp_l.push_back(mk(2'd1, c + LAT + DEB + LNG - 1));
      exp_mode = exp_mode + 2'd1;
      repeat (20) @(negedge clk);
      vectors++;
      if (kif_l.mode !== exp_mode) begin
        errors++;
        $display("FAIL long_mode[%0d]: got %0d, expected %0d", i, kif_l.mode, exp_mode);
      end
      vectors++;
      if (kif_l.key_state !== exp_state) begin
        errors++;
        $display("FAIL long_state[%0d]: got %b, expected %b", i, kif_l.key_state, exp_state);
      end
      while (exp_l.size() != 0 || act_l.size() != 0) begin
        vectors++;
        if (act_l.size() == 0) begin
          e = exp_l.pop_front(); errors++;
          $display("FAIL long_missing: got none, expected %s at cycle %0d", kname(e.kind), e.cyc);
        end else if (exp_l.size() == 0) begin
          a = act_l.pop_front(); errors++;
          $display("FAIL long_extra: got %s at cycle %0d, expected none", kname(a.kind), a.cyc);
        end else begin
          e = exp_l.pop_front(); a = act_l.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL long_event: got %s at cycle %0d, expected %s at cycle %0d",
                     kname(a.kind), a.cyc, kname(e.kind), e.cyc);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_hold;
    int c, c2, d;
    ev_t e, a;
    press_lo(20, c);
    exp_l.push_back(mk(2'd0, c + LAT + DEB));
    exp_l.push_back(mk(2'd2, c + 20 + LAT + DEB));
    exp_state = ~exp_state;
    repeat (15) @(negedge clk);
    @(negedge clk);
    c2 = cyc;
    kif_l.key_in = 1'b0;
    exp_l.push_back(mk(2'd0, c2 + LAT + DEB));
    // hcnt has counted 20 cycles of hold at this point
    repeat (LAT + DEB + 20) @(negedge clk);
    rst_n = 1'b0;
    exp_state = 1'b0;
    exp_mode = 2'd0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({kif_l.key_state, kif_l.key_press, kif_l.key_long, kif_l.mode} !== 5'b0) begin
      errors++;
      $display("FAIL midhold_cleared: got %b, expected 00000",
               {kif_l.key_state, kif_l.key_press, kif_l.key_long, kif_l.mode});
    end
    @(negedge clk);
    rst_n = 1'b1;
    d = cyc;
    exp_l.push_back(mk(2'd0, d + LAT + DEB));
    exp_l.push_back(mk(2'd1, d + LAT + DEB + LNG - 1));
    exp_mode = 2'd1;
    repeat (60) @(negedge clk);
    kif_l.key_in = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if (kif_l.mode !== exp_mode) begin
      errors++;
      $display("FAIL midhold_mode: got %0d, expected %0d", kif_l.mode, exp_mode);
    end
    vectors++;
    if (kif_l.key_state !== exp_state) begin
      errors++;
      $display("FAIL midhold_state: got %b, expected %b", kif_l.key_state, exp_state);
    end
    while (exp_l.size() != 0 || act_l.size() != 0) begin
      vectors++;
      if (act_l.size() == 0) begin
        e = exp_l.pop_front(); errors++;
        $display("FAIL midhold_missing: got none, expected %s at cycle %0d", kname(e.kind), e.cyc);
      end else if (exp_l.size() == 0) begin
        a = act_l.pop_front(); errors++;
        $display("FAIL midhold_extra: got %s at cycle %0d, expected none", kname(a.kind), a.cyc);
      end else begin
        e = exp_l.pop_front(); a = act_l.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL midhold_event: got %s at cycle %0d, expected %s at cycle %0d",
                   kname(a.kind), a.cyc, kname(e.kind), e.cyc);
        end
      end
    end
  endtask

  task automatic test_active_high;
    int c;
    ev_t e, a;
    @(negedge clk);
    c = cyc;
    kif_h.key_in = 1'b1;
    repeat (20) @(negedge clk);
    kif_h.key_in = 1'b0;
    exp_h.push_back(mk(2'd0, c + LAT + DEB));
    exp_h.push_back(mk(2'd2, c + 20 + LAT + DEB));
    repeat (25) @(negedge clk);
    vectors++;
    if (kif_h.key_state !== 1'b1) begin
      errors++;
      $display("FAIL ahigh_state: got %b, expected 1", kif_h.key_state);
    end
    vectors++;
    if (kif_h.mode !== 2'd0) begin
      errors++;
      $display("FAIL ahigh_mode: got %0d, expected 0", kif_h.mode);
    end
    vectors++;
    if (act_l.size() != 0) begin
      errors++;
      $display("FAIL ahigh_lo_quiet: got %0d events on active-low unit, expected 0", act_l.size());
    end
    while (exp_h.size() != 0 || act_h.size() != 0) begin
      vectors++;
      if (act_h.size() == 0) begin
        e = exp_h.pop_front(); errors++;
        $display("FAIL ahigh_missing: got none, expected %s at cycle %0d", kname(e.kind), e.cyc);
      end else if (exp_h.size() == 0) begin
        a = act_h.pop_front(); errors++;
        $display("FAIL ahigh_extra: got %s at cycle %0d, expected none", kname(a.kind), a.cyc);
      end else begin
        e = exp_h.pop_front(); a = act_h.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL ahigh_event: got %s at cycle %0d, expected %s at cycle %0d",
                   kname(a.kind), a.cyc, kname(e.kind), e.cyc);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    kif_l.key_in = 1'b1;
    kif_h.key_in = 1'b0;
    exp_mode = 2'd0;
    exp_state = 1'b0;
    test_reset;
    test_glitch;
    test_short_press;
    test_bounce;
    test_long_press;
    test_reset_mid_hold;
    test_active_high;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
